// File: rtl/control.sv
// control: RV32I main decoder with registered datapath control outputs (one decode pipeline stage).
module control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic [2:0] imm_sel,
    output logic       alu_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       branch,
    output logic       jump
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;

    logic [3:0] alu_op_d, alu_op_q, alu_f3;
    logic [2:0] imm_sel_d, imm_sel_q;
    logic [1:0] wb_sel_d, wb_sel_q;
    logic       alu_src_d, alu_src_q, mem_read_d, mem_read_q, mem_write_d, mem_write_q;
    logic       reg_write_d, reg_write_q, branch_d, branch_q, jump_d, jump_q;
    logic       alt;

    // Shared funct3 -> ALU map for R and I-ALU; funct7[5] selects the SUB/SRA variants.
    always_comb begin
        alu_f3 = ALU_ADD;
        case (funct3)
            3'b000: alu_f3 = ALU_ADD;
            3'b001: alu_f3 = ALU_SLL;
            3'b010: alu_f3 = ALU_SLT;
            3'b011: alu_f3 = ALU_SLTU;
            3'b100: alu_f3 = ALU_XOR;
            3'b101: alu_f3 = ALU_SRL;
            3'b110: alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    assign alt = funct7[5];

    always_comb begin
        alu_op_d    = ALU_ADD;
        imm_sel_d   = IMM_I;
        wb_sel_d    = WB_ALU;
        alu_src_d   = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        branch_d    = 1'b0;
        jump_d      = 1'b0;
        case (opcode)
            7'b0110011: begin
                reg_write_d = 1'b1;
                alu_op_d    = (alt && funct3 == 3'b000) ? ALU_SUB :
                              (alt && funct3 == 3'b101) ? ALU_SRA : alu_f3;
            end
            7'b0010011: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = (alt && funct3 == 3'b101) ? ALU_SRA : alu_f3;
            end
            7'b0000011: begin
                alu_src_d   = 1'b1;
                mem_read_d  = 1'b1;
                reg_write_d = 1'b1;
                wb_sel_d    = WB_MEM;
            end
            7'b0100011: begin
                alu_src_d   = 1'b1;
                imm_sel_d   = IMM_S;
                mem_write_d = 1'b1;
            end
            7'b1100011: begin
                branch_d  = 1'b1;
                imm_sel_d = IMM_B;
                alu_op_d  = !funct3[2] ? ALU_SUB : funct3[1] ? ALU_SLTU : ALU_SLT;
            end
            7'b1101111: begin
                jump_d      = 1'b1;
                imm_sel_d   = IMM_J;
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
                wb_sel_d    = WB_PC4;
            end
            7'b1100111: begin
                jump_d      = 1'b1;
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
                wb_sel_d    = WB_PC4;
            end
            7'b0110111: begin
                imm_sel_d   = IMM_U;
                alu_src_d   = 1'b1;
                alu_op_d    = ALU_PASSB;
                reg_write_d = 1'b1;
            end
            7'b0010111: begin
                imm_sel_d   = IMM_U;
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_q    <= ALU_ADD;
            imm_sel_q   <= IMM_I;
            wb_sel_q    <= WB_ALU;
            alu_src_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
        end else begin
            alu_op_q    <= alu_op_d;
            imm_sel_q   <= imm_sel_d;
            wb_sel_q    <= wb_sel_d;
            alu_src_q   <= alu_src_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
            branch_q    <= branch_d;
            jump_q      <= jump_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign imm_sel   = imm_sel_q;
    assign wb_sel    = wb_sel_q;
    assign alu_src   = alu_src_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign reg_write = reg_write_q;
    assign branch    = branch_q;
    assign jump      = jump_q;
endmodule

// File: tb/tb_control.sv
// tb_control: directed and randomized checks of the control decoder against a table-driven reference model.
module tb_control;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [3:0] alu_op;
    logic [2:0] imm_sel;
    logic [1:0] wb_sel;
    logic       alu_src, mem_read, mem_write, reg_write, branch, jump;
    logic [14:0] got;
    int checks = 0, errors = 0;

    control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_op(alu_op), .imm_sel(imm_sel), .alu_src(alu_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .wb_sel(wb_sel), .branch(branch), .jump(jump)
    );

    always #5 clk = ~clk;

    assign got = {alu_op, imm_sel, alu_src, mem_read, mem_write, reg_write, wb_sel, branch, jump};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {alu_op, imm_sel, alu_src, mem_read, mem_write, reg_write, wb_sel, branch, jump}.
    function automatic logic [14:0] model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int f3_alu[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int alu = 0, imm = 0, wb = 0;
        bit src = 0, mr = 0, mw = 0, rw = 0, br = 0, j = 0;
        logic [3:0] a;
        logic [2:0] im;
        logic [1:0] w;
        case (op)
            7'b0110011: begin rw = 1; alu = f3_alu[f3] + ((f7[5] && (f3 == 0 || f3 == 5)) ? 1 : 0); end
            7'b0010011: begin rw = 1; src = 1; alu = f3_alu[f3] + ((f7[5] && f3 == 5) ? 1 : 0); end
            7'b0000011: begin src = 1; mr = 1; rw = 1; wb = 1; end
            7'b0100011: begin src = 1; mw = 1; imm = 1; end
            7'b1100011: begin br = 1; imm = 2; alu = (f3 < 4) ? 1 : (f3 < 6) ? 3 : 4; end
            7'b1101111: begin j = 1; imm = 4; src = 1; rw = 1; wb = 2; end
            7'b1100111: begin j = 1; src = 1; rw = 1; wb = 2; end
            7'b0110111: begin imm = 3; src = 1; alu = 10; rw = 1; end
            7'b0010111: begin imm = 3; src = 1; rw = 1; end
            default: ;
        endcase
        a = alu[3:0];
        im = imm[2:0];
        w = wb[1:0];
        return {a, im, src, mr, mw, rw, w, br, j};
    endfunction

    task automatic step(input string tag, input logic r, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [14:0] exp;
        @(negedge clk);
        rst = r; opcode = op; funct3 = f3; funct7 = f7;
        exp = r ? 15'd0 : model(op, f3, f7);
        @(posedge clk);
        #1;
        check(tag, got, exp);
        check({tag, "_excl"}, {mem_read & mem_write, branch & jump, (mem_write | branch) & reg_write}, 0);
        // Inputs changing mid-cycle must not reach the outputs before the next edge.
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        #2;
        check({tag, "_hold"}, got, exp);
    endtask

    initial begin
        logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        rst = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0;
        step("rst1", 1, 7'b0110011, 3'b000, 7'b0000000);
        step("rst2", 1, 7'b0110011, 3'b000, 7'b0100000);
        check("rst_zero", got, 0);
        step("r_add", 0, 7'b0110011, 3'b000, 7'b0000000);
        step("r_sub", 0, 7'b0110011, 3'b000, 7'b0100000);
        step("i_addi", 0, 7'b0010011, 3'b000, 7'b0100000);
        check("addi_not_sub", alu_op, 0);
        step("i_srai", 0, 7'b0010011, 3'b101, 7'b0100000);
        check("srai_op", alu_op, 7);
        step("lw", 0, 7'b0000011, 3'b010, 7'b0);
        step("sw", 0, 7'b0100011, 3'b010, 7'b0);
        step("beq", 0, 7'b1100011, 3'b000, 7'b0);
        check("beq_op", alu_op, 1);
        step("bltu", 0, 7'b1100011, 3'b110, 7'b0);
        check("bltu_op", alu_op, 4);
        step("jal", 0, 7'b1101111, 3'b000, 7'b0);
        step("jalr", 0, 7'b1100111, 3'b000, 7'b0);
        step("lui", 0, 7'b0110111, 3'b000, 7'b0);
        check("lui_op", alu_op, 10);
        step("auipc", 0, 7'b0010111, 3'b000, 7'b0);
        step("nop", 0, 7'b1111111, 3'b111, 7'b1111111);
        step("rst_mid", 1, 7'b0000011, 3'b010, 7'b0);
        step("post_rst", 0, 7'b0110011, 3'b101, 7'b0100000);
        for (int i = 0; i < 400; i++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            step("rand", ($urandom_range(0, 19) == 0), op, 3'($urandom), 7'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
